// File: rtl/axp_pkg.sv
// Shared constants for the AXP opcode 13 integer multiply unit:
// function codes (cmd[11:5]), FSM state encodings and a sign-extend helper.
package axp_pkg;

  localparam logic [6:0] AXP_F_MULL  = 7'h00;
  localparam logic [6:0] AXP_F_MULQ  = 7'h20;
  localparam logic [6:0] AXP_F_UMULH = 7'h30;
  localparam logic [6:0] AXP_F_MULLV = 7'h40;
  localparam logic [6:0] AXP_F_MULQV = 7'h60;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/axp_mul_fixup.sv
// Result formatting for the opcode 13 multiplier: turns the 128-bit unsigned
// product into the architectural result and overflow flag per function.
module axp_mul_fixup
  import axp_pkg::*;
#(
  parameter bit SIGNED_FIX = 1'b1
) (
  input  logic [127:0] prod,
  input  logic [63:0]  opa,
  input  logic [63:0]  opb,
  input  logic [6:0]   fn,
  output logic [63:0]  y,
  output logic         ov
);

  logic [63:0] lo, uhi, shi;

  assign lo  = prod[63:0];
  assign uhi = prod[127:64];
  // Two's-complement correction of the unsigned high word; test builds skip it.
  assign shi = SIGNED_FIX ? (uhi - (opa[63] ? opb : 64'd0) - (opb[63] ? opa : 64'd0)) : uhi;

  always_comb begin
    y  = '0;
    ov = 1'b0;
    case (fn)
      AXP_F_MULL:  y = sext32(lo[31:0]);
      AXP_F_MULLV: begin
        y  = sext32(lo[31:0]);
        ov = !((&lo[63:31]) || !(|lo[63:31]));
      end
      AXP_F_MULQ:  y = lo;
      AXP_F_MULQV: begin
        y  = lo;
        ov = shi != {64{lo[63]}};
      end
      AXP_F_UMULH: y = uhi;
      default: ;
    endcase
  end

endmodule

// File: rtl/axp_mul_seq.sv
// Sequential AXP opcode 13 multiplier (MULL/MULQ/UMULH and /V forms),
// STEP multiplier bits per cycle. Optional AXP_MUL_EARLY_EXIT_EN ends the
// iteration as soon as the remaining multiplier bits are zero.
module axp_mul_seq
  import axp_pkg::*;
#(
  parameter int STEP       = 8,
  parameter bit SIGNED_FIX = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] cmd,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        kill,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] y,
  output logic        ov,
  output logic        busy
);

  localparam int         N        = 64 / STEP;
  localparam logic [6:0] CNT_LAST = 7'(N - 1);

  logic [1:0]       state;
  logic [6:0]       fn;
  logic [63:0]      opa, opb, mplier;
  logic [127:0]     acc, acc_nxt;
  logic [6:0]       count, sh;
  logic [63+STEP:0] pp;
  logic             last;
  logic [63:0]      fx_y;
  logic             fx_ov;
  logic [6:0]       f;
  logic             is_mull;
  logic             unused_cmd;

  assign f          = cmd[11:5];
  assign unused_cmd = ^{cmd[31:12], cmd[4:0]};
  assign is_mull    = (f == AXP_F_MULL) || (f == AXP_F_MULLV);

  assign sh      = 7'(count * STEP);
  assign pp      = {{STEP{1'b0}}, opa} * {64'd0, mplier[STEP-1:0]};
  assign acc_nxt = acc + (128'(pp) << sh);

`ifdef AXP_MUL_EARLY_EXIT_EN
  assign last = (mplier == '0) || (count == CNT_LAST);
`else
  assign last = (count == CNT_LAST);
`endif

  axp_mul_fixup #(.SIGNED_FIX(SIGNED_FIX)) u_fixup (
    .prod (acc_nxt),
    .opa  (opa),
    .opb  (opb),
    .fn   (fn),
    .y    (fx_y),
    .ov   (fx_ov)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      fn     <= '0;
      opa    <= '0;
      opb    <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      y      <= '0;
      ov     <= 1'b0;
    end else if (kill) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          fn     <= f;
          opa    <= is_mull ? sext32(a[31:0]) : a;
          opb    <= is_mull ? sext32(b[31:0]) : b;
          mplier <= is_mull ? sext32(b[31:0]) : b;
          acc    <= '0;
          count  <= '0;
          state  <= BUSY;
        end
        BUSY: begin
          acc    <= acc_nxt;
          mplier <= mplier >> STEP;
          count  <= count + 7'd1;
          if (last) begin
            y     <= fx_y;
            ov    <= fx_ov;
            state <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_axp_mul_seq.sv
// Directed self-checking bench for axp_mul_seq (STEP=8, default build).
module tb_axp_mul_seq;
  import axp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, kill, out_valid, out_ready, ov, busy;
  logic [31:0] cmd;
  logic [63:0] a, b, y;
  int          n_cmp = 0, n_err = 0;
  int          lat;
  logic        seen;

  always #5 clk = ~clk;

  axp_mul_seq #(.STEP(8), .SIGNED_FIX(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .cmd(cmd), .a(a), .b(b), .kill(kill), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .ov(ov), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [6:0] fc, input logic [63:0] aa, input logic [63:0] bb);
    in_valid = 1'b1;
    cmd      = {20'd0, fc, 5'd0};
    a        = aa;
    b        = bb;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int l);
    l = 0;
    while (!out_valid && l < 100) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic op(input string tag, input logic [6:0] fc, input logic [63:0] aa,
                    input logic [63:0] bb, input logic [63:0] ey, input logic eov);
    int l;
    start(fc, aa, bb);
    wait_done(l);
    chk({tag, "_lat"}, 64'(l), 64'd8);
    chk({tag, "_y"}, y, ey);
    chk({tag, "_ov"}, {63'd0, ov}, {63'd0, eov});
    take();
    chk({tag, "_rdy"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b0;
    cmd = '0; a = '0; b = '0;
    #23;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_y", y, 64'd0);
    chk("rst_ov", {63'd0, ov}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    op("mulq_3x5", AXP_F_MULQ, 64'd3, 64'd5, 64'd15, 1'b0);
    op("umulh_ff", AXP_F_UMULH, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    op("mulq_ff", AXP_F_MULQ, '1, '1, 64'd1, 1'b0);
    op("mullv_ovf", AXP_F_MULLV, 64'h4000_0000, 64'd2, 64'hFFFF_FFFF_8000_0000, 1'b1);
    op("mull_16", AXP_F_MULL, 64'h10, 64'h10, 64'h100, 1'b0);
    op("mulqv_ovf", AXP_F_MULQV, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1'b1);
    op("mulqv_neg", AXP_F_MULQV, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0);
    op("mull_hi_ign", AXP_F_MULL, 64'hABCD_0000_0000_0003, 64'h1234_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    op("bad_fn", 7'h11, 64'd9, 64'd9, 64'd0, 1'b0);

    // kill during BUSY
    start(AXP_F_MULQ, 64'd100, 64'd200);
    @(posedge clk); #1;
    @(posedge clk); #1;
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill_in_ready", {63'd0, in_ready}, 64'd1);
    chk("kill_busy", {63'd0, busy}, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    chk("kill_no_valid", {63'd0, seen}, 64'd0);
    op("mulq_7x6", AXP_F_MULQ, 64'd7, 64'd6, 64'd42, 1'b0);

    // kill blocks acceptance in IDLE
    in_valid = 1'b1; kill = 1'b1; cmd = {20'd0, AXP_F_MULQ, 5'd0};
    @(posedge clk); #1;
    in_valid = 1'b0; kill = 1'b0;
    chk("kill_idle_busy", {63'd0, busy}, 64'd0);

    // result held while consumer stalls
    start(AXP_F_MULQV, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3);
    wait_done(lat);
    chk("stall_lat", 64'(lat), 64'd8);
    for (int i = 0; i < 5; i++) begin
      chk("stall_y", y, 64'hFFFF_FFFF_FFFF_FFFA);
      chk("stall_ov", {63'd0, ov}, 64'd0);
      chk("stall_valid", {63'd0, out_valid}, 64'd1);
      chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
      @(posedge clk); #1;
    end
    take();

    // kill wins over out_ready in DONE
    start(AXP_F_MULQ, 64'd11, 64'd11);
    wait_done(lat);
    chk("kdone_valid", {63'd0, out_valid}, 64'd1);
    kill = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0; out_ready = 1'b0;
    chk("kdone_out_valid", {63'd0, out_valid}, 64'd0);
    chk("kdone_in_ready", {63'd0, in_ready}, 64'd1);

    // asynchronous reset mid-BUSY
    start(AXP_F_UMULH, '1, '1);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_y", y, 64'd0);
    chk("arst_ov", {63'd0, ov}, 64'd0);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    op("post_rst", AXP_F_MULQ, 64'd3, 64'd5, 64'd15, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
